// File: rtl/data1_tx.sv
// DDR source-synchronous transmitter: FIFO of d0/d1 sample pairs, forwarded clock DCO = clk/2.
// Optional macro DATA1_TX_TESTPAT_EN replaces idle slots with a 16-bit incrementing ramp.
module data1_tx #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          SYNC_CYCLES = 16,
    parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        Adc1DCO_po,
    output logic        Adc1DCO_no,
    output logic [15:0] Adc1Data_po,
    output logic [15:0] Adc1Data_no,
    output logic        underrun
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = (2 * SYNC_CYCLES > 1) ? $clog2(2 * SYNC_CYCLES) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] SYNC_LAST = SW'(2 * SYNC_CYCLES - 1);

    typedef enum logic {SYNC, RUN} state_t;

    state_t         state_q;
    logic           dco_q;
    logic           dco_n_q;
    logic [15:0]    data_q;
    logic [15:0]    data_n_q;
    logic           underrun_q;
    logic           slot_pop_q;
    logic [15:0]    d1_lat_q;
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [SW-1:0]  sync_cnt_q;
    logic [31:0]    mem [FIFO_DEPTH];

    logic           rise;
    logic           push;
    logic           pop;
    logic [31:0]    rd_pair;
    logic [15:0]    data_d;
    logic           idle_slot;
    logic [15:0]    idle_word;

    assign in_ready = rst_n && (count_q < DEPTH_C);

    always_comb begin
        rise      = (state_q == RUN) && !dco_q;
        push      = in_valid && in_ready;
        pop       = rise && (count_q != '0);
        rd_pair   = mem[rd_ptr_q];
        data_d    = idle_word;
        idle_slot = 1'b1;
        if (pop) begin
            data_d    = rd_pair[31:16];
            idle_slot = 1'b0;
        end else if ((state_q == RUN) && dco_q && slot_pop_q) begin
            data_d    = d1_lat_q;
            idle_slot = 1'b0;
        end
    end

`ifdef DATA1_TX_TESTPAT_EN
    logic [15:0] ramp_q;

    assign idle_word = ramp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q <= 16'h0000;
        end else if (idle_slot) begin
            ramp_q <= ramp_q + 16'h0001;
        end
    end
`else
    assign idle_word = IDLE_WORD;
`endif

    // Storage array has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {d0, d1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SYNC;
            dco_q      <= 1'b0;
            dco_n_q    <= 1'b1;
            data_q     <= IDLE_WORD;
            data_n_q   <= ~IDLE_WORD;
            underrun_q <= 1'b0;
            slot_pop_q <= 1'b0;
            d1_lat_q   <= 16'h0000;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sync_cnt_q <= '0;
        end else begin
            dco_q      <= ~dco_q;
            dco_n_q    <= dco_q;
            data_q     <= data_d;
            data_n_q   <= ~data_d;
            underrun_q <= rise && !pop && slot_pop_q;
            if (rise) begin
                slot_pop_q <= pop;
            end
            if (pop) begin
                d1_lat_q <= rd_pair[15:0];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Leave SYNC on the edge that drives DCO low so RUN starts on a rise.
            if (state_q == SYNC) begin
                sync_cnt_q <= sync_cnt_q + 1'b1;
                if ((sync_cnt_q == SYNC_LAST) && dco_q) begin
                    state_q <= RUN;
                end
            end
        end
    end

    assign Adc1DCO_po  = dco_q;
    assign Adc1DCO_no  = dco_n_q;
    assign Adc1Data_po = data_q;
    assign Adc1Data_no = data_n_q;
    assign underrun    = underrun_q;

endmodule

// File: doc/data1_tx.md
DATA1_TX -- requirements
Module: data1_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit sample-pair entries; power of two, 2..16.
REQ-002 Parameter SYNC_CYCLES, default 16, idle DCO periods emitted after reset before data is sent.
REQ-003 Parameter IDLE_WORD, default 16'h0000, data driven on Adc1Data_po when no sample is sent.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 d0  input  16  first sample of pair, sent on DCO rising phase.
REQ-007 d1  input  16  second sample of pair, sent on DCO falling phase.
REQ-008 in_valid  input  1  d0/d1 pair valid.
REQ-009 in_ready  output  1  FIFO can accept a pair.
REQ-010 Adc1DCO_po / Adc1DCO_no  output  1 each  forwarded data clock, complementary pair.
REQ-011 Adc1Data_po / Adc1Data_no  output  16 each  DDR data, complementary pair.
REQ-012 underrun  output  1  one-cycle pulse when a pair slot goes idle after data was flowing.

Function
REQ-013 All outputs SHALL be registered; Adc1DCO_no == ~Adc1DCO_po and Adc1Data_no == ~Adc1Data_po at all times.
REQ-014 Adc1DCO_po SHALL toggle every clk cycle from the first edge after reset release (DCO = clk/2, continuous).
REQ-015 Transfer SHALL occur on a rising clk edge where in_valid && in_ready; pair written to FIFO tail.
REQ-016 in_ready SHALL equal (fifo count < FIFO_DEPTH), combinational from count; in_valid while !in_ready is ignored, no data loss claimed.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; pop from empty and push to full SHALL never happen.
REQ-018 States: SYNC, RUN. SYNC after reset; after 2*SYNC_CYCLES clk cycles move to RUN on the edge where DCO goes low, staying RUN until reset.
REQ-019 In SYNC, Adc1Data_po SHALL be IDLE_WORD; FIFO accepts pushes but is never popped.
REQ-020 In RUN, on each edge driving DCO 0->1: if FIFO non-empty, pop, drive d0, latch d1; else drive IDLE_WORD and mark slot idle.
REQ-021 In RUN, on each edge driving DCO 1->0: drive latched d1 if slot was a pop, else IDLE_WORD.
REQ-022 Latency: a pair pushed into empty FIFO at edge k in RUN SHALL appear at the first DCO-rise edge >= k+1 (1 or 2 cycles).
REQ-023 underrun SHALL pulse for one cycle at a DCO-rise edge in RUN where FIFO is empty and the previous pair slot was a pop.
REQ-024 Pair order SHALL be preserved; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-025 While rst_n=0: Adc1DCO_po=0, Adc1DCO_no=1, Adc1Data_po=IDLE_WORD, Adc1Data_no=~IDLE_WORD, underrun=0, state SYNC, FIFO empty, in_ready=0.
REQ-026 Reset asserted mid-pair SHALL abort immediately; FIFO contents discarded; after release in_ready=1 from the first cycle.

Configuration
REQ-027 Macro DATA1_TX_TESTPAT_EN: when defined, every idle slot (SYNC and RUN) SHALL carry a 16-bit ramp incrementing by 1 per slot, reset to 0, wrapping at 16'hFFFF, instead of IDLE_WORD; when undefined, no ramp logic and IDLE_WORD is used.

Verification
REQ-028 Reset release, no input -> DCO toggles each cycle, data_po=16'h0000 for all cycles, underrun never pulses.
REQ-029 After RUN, push d0=16'hE5E3, d1=16'h1A1C once -> data_po=E5E3 with DCO=1, then 1A1C with DCO=0, data_no=1A1C/E5E3, then idle and one underrun pulse.
REQ-030 Continuous valid with pairs (n, n+1000) for n=0..63 -> output sequence 0,1000,1,1001,... no idle gaps, in_ready held low when 4 entries full.
REQ-031 Push 4 pairs during SYNC -> in_ready=0 after 4th; first d0 appears on first DCO rise in RUN.
REQ-032 Assert rst_n=0 mid-stream with 3 entries queued -> outputs at reset values in same cycle; after release no stale data emitted.
REQ-033 Build with DATA1_TX_TESTPAT_EN, no input -> data_po reads 0,1,2,3,... on consecutive slots, wrapping FFFF->0000.
